song_recorder: RTL and testbench

Captures live play on the 7-key keyboard as a sequence of (note, duration) entries in an internal buffer, for later replay by the learning/playback path. It is the writer for the song-entry format the playback path reads: each entry is a 3-bit note code plus an 8-bit duration in ticks. A one-cycle-latency read port lets a player walk the recorded entries by address.

---
 rtl/song_recorder.sv | 99 +++++++++
 tb/tb_song_recorder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/song_recorder.sv
// song_recorder: records live keyboard play as {note, duration} entries readable by address
module song_recorder #(
  parameter int DEPTH = 64,
  parameter int TICK_DIV = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rec_en,
  input  logic                       clear,
  input  logic [6:0]                 key_in,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [10:0]                rd_data,
  output logic [$clog2(DEPTH):0]     length,
  output logic                       recording,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TWRAP = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] THIT = TW'(TICK_DIV > 1 ? TICK_DIV - 2 : 0);
  localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, FLUSH, FULL} state_t;
  state_t r_state;
  logic [6:0] r_k1, r_k2;
  logic [2:0] r_cur;
  logic [7:0] r_dur;
  logic [TW-1:0] r_tick;
  logic [AW:0] r_len;
  logic r_rec, r_full;
  logic [10:0] r_rd;
  logic [10:0] r_mem [DEPTH];
  logic [2:0] w_code;
  logic w_chg, w_hit, w_sat, w_flush, w_we;
  always_comb begin
    w_code = 3'd0;
    for (int i = 6; i >= 0; i--) if (r_k2[i]) w_code = 3'(i + 1);
  end
  assign w_chg = r_state == CAPTURE && rec_en && w_code != r_cur;
  // the cycle a note starts already counts, so a tick lands one count before wrap
  assign w_hit = r_state == CAPTURE && rec_en && !w_chg && r_tick == THIT;
  assign w_sat = w_hit && r_dur == 8'hFF;
  assign w_flush = r_state == FLUSH && r_dur != 8'd0 && r_cur != 3'd0;
  assign w_we = !reset && !clear && ((w_chg && r_dur != 8'd0) || w_sat || w_flush);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k1 <= '0;
      r_k2 <= '0;
      r_cur <= '0;
      r_dur <= '0;
      r_tick <= '0;
      r_len <= '0;
      r_rec <= 1'b0;
      r_full <= 1'b0;
    end else begin
      r_k1 <= key_in;
      r_k2 <= r_k1;
      r_rec <= r_state == ARMED || r_state == CAPTURE;
      r_full <= r_state == FULL;
      if (w_we) r_len <= r_len + 1'b1;
      if (clear) begin
        r_len <= '0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (rec_en) begin
            r_state <= ARMED;
            r_len <= '0;
          end
          ARMED: if (!rec_en) r_state <= IDLE;
          else if (w_code != 3'd0) begin
            r_cur <= w_code;
            r_dur <= '0;
            r_tick <= '0;
            r_state <= CAPTURE;
          end
          CAPTURE: if (!rec_en) r_state <= FLUSH;
          else if (w_chg) begin
            r_cur <= w_code;
            r_dur <= '0;
            r_tick <= '0;
          end else begin
            r_tick <= r_tick == TWRAP ? '0 : r_tick + 1'b1;
            if (w_hit) r_dur <= w_sat ? 8'd0 : r_dur + 8'd1;
          end
          FLUSH: r_state <= IDLE;
          default: ;
        endcase
        if (w_we && r_len == LAST) r_state <= FULL;
      end
    end
  end
  always_ff @(posedge clk) if (w_we) r_mem[r_len[AW-1:0]] <= {r_cur, r_dur};
  always_ff @(posedge clk) r_rd <= reset ? '0 : r_mem[rd_addr];
  assign rd_data = r_rd;
  assign length = r_len;
  assign recording = r_rec;
  assign full = r_full;
endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed and random takes checked against a run-length model of the recorder
module tb_song_recorder;
  localparam int DEPTH = 8;
  localparam int TICK = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rec_en = 1'b0;
  logic clear = 1'b0;
  logic [6:0] key_in = '0;
  logic [2:0] rd_addr = '0;
  logic [10:0] rd_data;
  logic [3:0] length;
  logic recording, full;
  int n_cmp = 0;
  int n_bad = 0;
  int t0;
  logic h_rec[$];
  logic [6:0] h_key[$];
  logic [10:0] exp_q[$];
  song_recorder #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
    .clk(clk), .reset(reset), .rec_en(rec_en), .clear(clear), .key_in(key_in),
    .rd_addr(rd_addr), .rd_data(rd_data), .length(length), .recording(recording), .full(full)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic [6:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      rec_en = r;
      key_in = k;
      h_rec.push_back(r);
      h_key.push_back(k);
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [2:0] code_of(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return 3'(i + 1);
    return 3'd0;
  endfunction
  // a take seen as runs of note codes: each run is floor(cycles/TICK) ticks, split at 256
  task automatic build(input int c0);
    logic [2:0] codes[$];
    logic [2:0] r;
    int n, d;
    exp_q.delete();
    for (int c = c0 + 1; c < h_rec.size() && h_rec[c]; c++)
      codes.push_back(c >= 2 ? code_of(h_key[c-2]) : 3'd0);
    while (codes.size() > 0 && codes[0] == 3'd0) void'(codes.pop_front());
    while (codes.size() > 0) begin
      r = codes[0];
      n = 0;
      while (codes.size() > 0 && codes[0] == r) begin
        void'(codes.pop_front());
        n++;
      end
      d = n / TICK;
      for (int s = 0; s < d / 256; s++) exp_q.push_back({r, 8'd255});
      if (d % 256 != 0 && (codes.size() > 0 || r != 3'd0)) exp_q.push_back({r, 8'(d % 256)});
    end
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
  endtask
  task automatic finish_take(input int c0);
    step(0, 7'd0, 3);
    build(c0);
    chk("length", 32'(length), exp_q.size());
    chk("recording_after", 32'(recording), 0);
    chk("full_after", 32'(full), 32'(exp_q.size() == DEPTH));
    foreach (exp_q[i]) begin
      rd_addr = 3'(i);
      step(0, 7'd0, 1);
      chk($sformatf("entry%0d", i), 32'(rd_data), 32'(exp_q[i]));
    end
  endtask
  task automatic read_chk(input string tag, input int a, input logic [10:0] exp);
    rd_addr = 3'(a);
    step(0, 7'd0, 1);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask
  task automatic clr();
    clear = 1'b1;
    step(0, 7'd0, 1);
    clear = 1'b0;
    chk("clr_len", 32'(length), 0);
    step(0, 7'd0, 1);
    chk("clr_full", 32'(full), 0);
  endtask
  initial begin
    step(0, 7'd0, 3);
    reset = 1'b0;
    chk("rst_len", 32'(length), 0);
    chk("rst_rec", 32'(recording), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_rd", 32'(rd_data), 0);
    t0 = h_rec.size();
    step(1, 7'd0, 1);
    step(1, 7'h01, 12);
    chk("t1_rec", 32'(recording), 1);
    step(1, 7'h04, 8);
    step(1, 7'd0, 2);
    finish_take(t0);
    chk("t1_len", 32'(length), 2);
    read_chk("t1_e0", 0, {3'd1, 8'd3});
    read_chk("t1_e1", 1, {3'd3, 8'd2});
    clr();
    t0 = h_rec.size();
    step(1, 7'd0, 1);
    step(1, 7'h01, 8);
    step(1, 7'h02, 2);
    step(1, 7'h04, 8);
    step(1, 7'd0, 2);
    finish_take(t0);
    read_chk("gl_e0", 0, {3'd1, 8'd2});
    read_chk("gl_e1", 1, {3'd3, 8'd2});
    clr();
    t0 = h_rec.size();
    step(1, 7'd0, 5);
    step(1, 7'h08, 8);
    step(1, 7'd0, 12);
    finish_take(t0);
    chk("rest_len", 32'(length), 1);
    read_chk("rest_e0", 0, {3'd4, 8'd2});
    clr();
    t0 = h_rec.size();
    step(1, 7'd0, 1);
    step(1, 7'h10, 1040);
    step(1, 7'd0, 2);
    finish_take(t0);
    read_chk("sat_e0", 0, {3'd5, 8'd255});
    read_chk("sat_e1", 1, {3'd5, 8'd4});
    clr();
    t0 = h_rec.size();
    step(1, 7'd0, 1);
    for (int i = 0; i < 10; i++) step(1, 7'(1 << (i % 7)), 16);
    chk("full_flag", 32'(full), 1);
    chk("full_rec", 32'(recording), 0);
    step(1, 7'h01, 20);
    finish_take(t0);
    chk("full_len", 32'(length), DEPTH);
    clr();
    step(1, 7'd0, 1);
    step(1, 7'h01, 12);
    step(1, 7'h02, 2);
    chk("cc_rec", 32'(recording), 1);
    clear = 1'b1;
    step(1, 7'h02, 1);
    clear = 1'b0;
    chk("cc_len", 32'(length), 0);
    step(0, 7'd0, 1);
    chk("cc_idle", 32'(recording), 0);
    step(0, 7'd0, 2);
    chk("cc_len2", 32'(length), 0);
    step(1, 7'd0, 1);
    step(1, 7'h01, 12);
    step(1, 7'h02, 12);
    chk("rm_len_pre", 32'(length), 1);
    reset = 1'b1;
    step(1, 7'h02, 1);
    reset = 1'b0;
    chk("rm_len", 32'(length), 0);
    chk("rm_rec", 32'(recording), 0);
    chk("rm_full", 32'(full), 0);
    chk("rm_rd", 32'(rd_data), 0);
    step(0, 7'd0, 3);
    for (int r = 0; r < 6; r++) begin
      t0 = h_rec.size();
      step(1, 7'd0, $urandom_range(1, 4));
      repeat ($urandom_range(2, 9))
        step(1, ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127)), $urandom_range(1, 24));
      finish_take(t0);
      clr();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
